// File: rtl/gcd_binary_iter_responder.sv
`default_nettype none
// ============================================================================
// Module      : gcd_binary_iter_responder
// Description : Iterative binary (Stein) GCD responder. A one-cycle start
//               pulse latches a and b; the unit strips common factors of two,
//               reduces by shift/subtract one step per cycle, and writes
//               result = gcd(a, b). result_ready signals an idle, valid result.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_binary_iter_responder #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         result_ready
);

    // Shift counter must hold values up to W.
    localparam int KW = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_ZCHK   = 2'd1,
        ST_STRIP  = 2'd2,
        ST_REDUCE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   u_q, u_d;
    logic [W-1:0]   v_q, v_d;
    logic [KW-1:0]  k_q, k_d;
    logic [W-1:0]   result_q, result_d;

    // Next-state and datapath: a start always wins and restarts the job,
    // silently dropping any job in flight.
    always_comb begin
        state_d  = state_q;
        u_d      = u_q;
        v_d      = v_q;
        k_d      = k_q;
        result_d = result_q;
        if (start) begin
            u_d     = a;
            v_d     = b;
            k_d     = '0;
            state_d = ST_ZCHK;
        end else begin
            case (state_q)
                ST_ZCHK: begin
                    // A zero operand makes the answer the other operand.
                    if ((u_q == '0) || (v_q == '0)) begin
                        result_d = u_q | v_q;
                        state_d  = ST_READY;
                    end else begin
                        state_d = ST_STRIP;
                    end
                end
                ST_STRIP: begin
                    // Remove common powers of two, remembering how many.
                    if (!u_q[0] && !v_q[0]) begin
                        u_d = u_q >> 1;
                        v_d = v_q >> 1;
                        k_d = k_q + KW'(1);
                    end else begin
                        state_d = ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    // At least one of u, v is odd here; difference of two odd
                    // values is even, so it is halved in the same step.
                    if (u_q == v_q) begin
                        result_d = u_q << k_q;
                        state_d  = ST_READY;
                    end else if (!u_q[0]) begin
                        u_d = u_q >> 1;
                    end else if (!v_q[0]) begin
                        v_d = v_q >> 1;
                    end else if (u_q > v_q) begin
                        u_d = (u_q - v_q) >> 1;
                    end else begin
                        v_d = (v_q - u_q) >> 1;
                    end
                end
                default: begin
                    state_d = ST_READY;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset to an idle, zero result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_READY;
            u_q      <= '0;
            v_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            u_q      <= u_d;
            v_q      <= v_d;
            k_q      <= k_d;
            result_q <= result_d;
        end
    end

    assign result       = result_q;
    // Ready drops combinationally in the same cycle the initiator pulses start.
    assign result_ready = (state_q == ST_READY) & ~start & rst_n;

endmodule
`default_nettype wire
